// File: rtl/pfs_pattern_engine_pkg.sv
// -----------------------------------------------------------------------------
// pfs_pkg
// Shared definitions for the parallel fault simulator pattern engine:
//   - pfs_state_e : engine FSM encoding
//   - GOOD_LANE   : lane index of the fault-free machine
//   - lfsr_taps   : maximal-length Fibonacci tap mask for widths 3..16
//   - parity16    : XOR reduction used for LFSR feedback
//   - rsp_idx     : bit position of output j of lane k in a packed response
// -----------------------------------------------------------------------------
package pfs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } pfs_state_e;

  localparam int GOOD_LANE = 0;

  // Tap mask, bit t set means register bit t feeds the XOR. Widths outside
  // 3..16 have no entry and yield an all-zero mask.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  // Even-parity bit of a 16-bit vector.
  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

  // Packed response layout: output j of lane k lives at bit j*lanes+k.
  function automatic int rsp_idx(input int j, input int k, input int lanes);
    return j * lanes + k;
  endfunction

endpackage

// File: rtl/pfs_pattern_engine_if.sv
// -----------------------------------------------------------------------------
// pfs_pattern_engine_if
// Pattern and response channels between the pattern engine and the
// bit-parallel evaluator.
//   pat_valid/pat_ready/pat_data : pattern channel, engine -> evaluator
//   rsp_valid/rsp_ready/rsp_data : response channel, evaluator -> engine
// Modports:
//   master : engine side
//   slave  : evaluator side
// -----------------------------------------------------------------------------
interface pfs_pattern_engine_if #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 2,
  parameter int LANES = 16
) ();

  logic                   pat_valid;
  logic                   pat_ready;
  logic [N_IN-1:0]        pat_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [N_OUT*LANES-1:0] rsp_data;

  modport master (
    output pat_valid,
    output pat_data,
    output rsp_ready,
    input  pat_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  pat_valid,
    input  pat_data,
    input  rsp_ready,
    output pat_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/pfs_pattern_engine_gen.sv
// -----------------------------------------------------------------------------
// pfs_pattern_gen
// Pattern source for the engine: exhaustive up-counter (PAT_MODE=0) or
// maximal-length Fibonacci LFSR (PAT_MODE=1, N_IN in 3..16).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : reload the start value (0, or the seed in LFSR mode)
//   step_i     : advance one pattern (ignored while load_i is high)
//   pat_o      : current pattern, registered
// A seed of 0 would lock the LFSR, so it is replaced by 1.
// -----------------------------------------------------------------------------
module pfs_pattern_gen
  import pfs_pkg::*;
#(
  parameter int N_IN      = 5,
  parameter int PAT_MODE  = 0,
  parameter int LFSR_SEED = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  output logic [N_IN-1:0] pat_o
);

  localparam logic [N_IN-1:0] ONE_V    = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] SEED_RAW = N_IN'(LFSR_SEED);
  localparam logic [N_IN-1:0] SEED_V   = (SEED_RAW == '0) ? ONE_V : SEED_RAW;
  localparam logic [N_IN-1:0] START_V  = (PAT_MODE == 1) ? SEED_V : '0;
  localparam logic [N_IN-1:0] TAP_W    = N_IN'(lfsr_taps(N_IN));

  logic [N_IN-1:0] pat_q;
  logic [N_IN-1:0] pat_d;
  logic [N_IN-1:0] step_val;

  // Next pattern: counter increment (wraps at 2^N_IN) or one LFSR shift.
  always_comb begin
    if (PAT_MODE == 1) begin
      step_val = {pat_q[N_IN-2:0], parity16(16'(pat_q & TAP_W))};
    end else begin
      step_val = pat_q + ONE_V;
    end
  end

  // Load has priority over step.
  always_comb begin
    if (load_i) begin
      pat_d = START_V;
    end else if (step_i) begin
      pat_d = step_val;
    end else begin
      pat_d = pat_q;
    end
  end

  // Pattern register; reset leaves it at the start value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= START_V;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign pat_o = pat_q;

endmodule

// File: rtl/pfs_pattern_engine.sv
// -----------------------------------------------------------------------------
// pfs_pattern_engine
// Stimulus/response end of a parallel fault simulator. Issues one pattern at a
// time to a bit-parallel evaluator, takes back the packed per-lane response,
// and flags every faulty lane (1..LANES-1) whose outputs differ from the good
// lane 0. The detected mask is sticky for the whole run.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : begin a run (sampled only when idle)
//   pat_count_i     : number of patterns for the run (sampled with start_i)
//   bus (master)    : pattern/response channels to the evaluator
//   detected_o      : sticky mask of detected faulty lanes, bit 0 always 0
//   det_count_o     : popcount of detected_o
//   busy_o          : run in progress
//   done_o          : one-cycle pulse at end of run
//   all_detected_o  : every faulty lane detected
// -----------------------------------------------------------------------------
module pfs_pattern_engine
  import pfs_pkg::*;
#(
  parameter int N_IN       = 5,
  parameter int N_OUT      = 2,
  parameter int LANES      = 16,
  parameter int PAT_MODE   = 0,
  parameter int LFSR_SEED  = 1,
  parameter int EARLY_STOP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [15:0]              pat_count_i,
  pfs_pattern_engine_if.master     bus,
  output logic [LANES-1:0]         detected_o,
  output logic [$clog2(LANES):0]   det_count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     all_detected_o
);

  localparam int CW = $clog2(LANES) + 1;

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SEND  = ST_SEND;
  localparam logic [2:0] WAIT  = ST_WAIT;
  localparam logic [2:0] CHECK = ST_CHECK;
  localparam logic [2:0] DONE  = ST_DONE;

  logic [2:0]             state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            sent_q, sent_d;
  logic [N_OUT*LANES-1:0] rsp_q, rsp_d;
  logic [LANES-1:0]       det_q, det_d;
  logic [LANES-1:0]       diff;
  logic                   gen_load, gen_step;
  logic [N_IN-1:0]        gen_pat;

  logic                   pat_valid_q;
  logic                   rsp_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CW-1:0]          det_count_q;
  logic                   all_det_q;

  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {{(CW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic faulty_all_set(input logic [LANES-1:0] v);
    return &v[LANES-1:1];
  endfunction

  pfs_pattern_gen #(
    .N_IN      (N_IN),
    .PAT_MODE  (PAT_MODE),
    .LFSR_SEED (LFSR_SEED)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (gen_load),
    .step_i (gen_step),
    .pat_o  (gen_pat)
  );

  // Per-lane mismatch against the good lane over all outputs of the held response.
  always_comb begin
    diff = '0;
    for (int k = 1; k < LANES; k++) begin
      for (int j = 0; j < N_OUT; j++) begin
        diff[k] = diff[k] |
                  (rsp_q[rsp_idx(j, k, LANES)] ^ rsp_q[rsp_idx(j, GOOD_LANE, LANES)]);
      end
    end
  end

  // FSM next state and datapath updates. The early-stop test uses the mask
  // including this CHECK's contribution.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sent_d   = sent_q;
    rsp_d    = rsp_q;
    det_d    = det_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          det_d    = '0;
          cnt_d    = pat_count_i;
          sent_d   = 16'd0;
          gen_load = 1'b1;
          if (pat_count_i == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.pat_ready) begin
          sent_d  = sent_q + 16'd1;
          state_d = WAIT;
        end else begin
          state_d = SEND;
        end
      end
      WAIT: begin
        if (bus.rsp_valid) begin
          rsp_d   = bus.rsp_data;
          state_d = CHECK;
        end else begin
          state_d = WAIT;
        end
      end
      CHECK: begin
        det_d    = det_q | diff;
        gen_step = 1'b1;
        if ((sent_q == cnt_q) || ((EARLY_STOP != 0) && faulty_all_set(det_d))) begin
          state_d = DONE;
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      sent_q  <= 16'd0;
      rsp_q   <= '0;
      det_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      rsp_q   <= rsp_d;
      det_q   <= det_d;
    end
  end

  // Output flops decoded from the next state so every output is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_count_q <= '0;
      all_det_q   <= 1'b0;
    end else begin
      pat_valid_q <= (state_d == SEND);
      rsp_ready_q <= (state_d == WAIT);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      det_count_q <= popcount(det_d);
      all_det_q   <= faulty_all_set(det_d);
    end
  end

  // The generator register is valid whenever SEND is entered (loaded or stepped
  // on that same edge); masking with pat_valid keeps pat_data at 0 otherwise,
  // including after reset when the LFSR already holds its seed.
  assign bus.pat_data  = gen_pat & {N_IN{pat_valid_q}};
  assign bus.pat_valid = pat_valid_q;
  assign bus.rsp_ready = rsp_ready_q;

  assign detected_o     = det_q;
  assign det_count_o    = det_count_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign all_detected_o = all_det_q;

endmodule

// File: tb/tb_pfs_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_pfs_pattern_engine
// Directed bench for pfs_pattern_engine with LANES=4, N_IN=5, N_OUT=2.
//   u_dut_a : exhaustive counter, EARLY_STOP=1
//   u_dut_b : LFSR, seed 0 (replaced by 1)
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pfs_pattern_engine;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  det_a, det_b;
  logic [2:0]  dc_a, dc_b;
  logic        busy_a, busy_b, done_a, done_b, alld_a, alld_b;

  int n_chk = 0;
  int n_bad = 0;

  pfs_pattern_engine_if #(.N_IN(5), .N_OUT(2), .LANES(4)) if_a ();
  pfs_pattern_engine_if #(.N_IN(5), .N_OUT(2), .LANES(4)) if_b ();

  pfs_pattern_engine #(
    .N_IN(5), .N_OUT(2), .LANES(4), .PAT_MODE(0), .LFSR_SEED(1), .EARLY_STOP(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .pat_count_i(cnt_a), .bus(if_a),
    .detected_o(det_a), .det_count_o(dc_a), .busy_o(busy_a), .done_o(done_a),
    .all_detected_o(alld_a)
  );

  pfs_pattern_engine #(
    .N_IN(5), .N_OUT(2), .LANES(4), .PAT_MODE(1), .LFSR_SEED(0), .EARLY_STOP(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .pat_count_i(cnt_b), .bus(if_b),
    .detected_o(det_b), .det_count_o(dc_b), .busy_o(busy_b), .done_o(done_b),
    .all_detected_o(alld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse start on engine A for one cycle; returns one cycle after it was sampled.
  task automatic start_run(input logic [15:0] n);
    cnt_a   = n;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Accept one pattern from engine A, check it, and answer with rsp.
  // Returns at the falling edge inside CHECK.
  task automatic send_pat(input logic [4:0] exp_pat, input logic [7:0] rsp);
    int t;
    t = 0;
    while (if_a.pat_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("pat_valid", 32'(if_a.pat_valid), 32'd1);
    check_val("pat_data", 32'(if_a.pat_data), 32'(exp_pat));
    check_val("rsp_ready_in_send", 32'(if_a.rsp_ready), 32'd0);
    if_a.pat_ready = 1'b1;
    @(negedge clk);
    if_a.pat_ready = 1'b0;
    check_val("pat_valid_after_hs", 32'(if_a.pat_valid), 32'd0);
    check_val("rsp_ready_in_wait", 32'(if_a.rsp_ready), 32'd1);
    if_a.rsp_valid = 1'b1;
    if_a.rsp_data  = rsp;
    @(negedge clk);
    if_a.rsp_valid = 1'b0;
    if_a.rsp_data  = 8'h00;
    check_val("rsp_ready_in_check", 32'(if_a.rsp_ready), 32'd0);
  endtask

  // From CHECK of the final pattern: done must pulse exactly on the next cycle.
  task automatic expect_done(input logic [3:0] e_det, input logic [2:0] e_dc, input logic e_all);
    check_val("done_early", 32'(done_a), 32'd0);
    @(negedge clk);
    check_val("done_pulse", 32'(done_a), 32'd1);
    check_val("busy_in_done", 32'(busy_a), 32'd1);
    check_val("pat_valid_in_done", 32'(if_a.pat_valid), 32'd0);
    check_val("detected", 32'(det_a), 32'(e_det));
    check_val("det_count", 32'(dc_a), 32'(e_dc));
    check_val("all_detected", 32'(alld_a), 32'(e_all));
    @(negedge clk);
    check_val("done_cleared", 32'(done_a), 32'd0);
    check_val("busy_cleared", 32'(busy_a), 32'd0);
    check_val("detected_held", 32'(det_a), 32'(e_det));
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    cnt_a   = 16'd0;
    cnt_b   = 16'd0;
    if_a.pat_ready = 1'b0; if_a.rsp_valid = 1'b0; if_a.rsp_data = 8'h00;
    if_b.pat_ready = 1'b0; if_b.rsp_valid = 1'b0; if_b.rsp_data = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("reset_a", {17'd0, if_a.pat_valid, if_a.rsp_ready, if_a.pat_data,
                          busy_a, done_a, det_a, dc_a, alld_a}, 32'd0);
    check_val("reset_b", {17'd0, if_b.pat_valid, if_b.rsp_ready, if_b.pat_data,
                          busy_b, done_b, det_b, dc_b, alld_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three patterns, all lanes agree
    start_run(16'd3);
    check_val("start_latency_valid", 32'(if_a.pat_valid), 32'd1);
    check_val("start_latency_busy", 32'(busy_a), 32'd1);
    send_pat(5'd0, 8'h00);
    send_pat(5'd1, 8'hFF);
    send_pat(5'd2, 8'h0F);
    expect_done(4'b0000, 3'd0, 1'b0);

    // Evaluator stalls 5 cycles; a start pulse while busy is ignored.
    // Pattern 1 flips output 1 of lane 2 (bit 1*4+2 = 6).
    start_run(16'd3);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_valid", 32'(if_a.pat_valid), 32'd1);
      check_val("stall_data", 32'(if_a.pat_data), 32'd0);
      check_val("stall_rsp_ready", 32'(if_a.rsp_ready), 32'd0);
      if (i == 2) begin
        cnt_a   = 16'd1;
        start_a = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    send_pat(5'd0, 8'h00);
    send_pat(5'd1, 8'h40);
    send_pat(5'd2, 8'h00);
    expect_done(4'b0100, 3'd1, 1'b0);

    // Early stop: lanes 1..3 differ on output 0 in the first response
    start_run(16'd4);
    send_pat(5'd0, 8'h0E);
    expect_done(4'b1110, 3'd3, 1'b1);

    // Zero-length run: done the cycle after start, detected cleared
    cnt_a   = 16'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_val("zero_done", 32'(done_a), 32'd1);
    check_val("zero_busy", 32'(busy_a), 32'd1);
    check_val("zero_valid", 32'(if_a.pat_valid), 32'd0);
    check_val("zero_detected", 32'(det_a), 32'd0);
    check_val("zero_all", 32'(alld_a), 32'd0);
    @(negedge clk);
    check_val("zero_done_off", 32'(done_a), 32'd0);
    check_val("zero_valid_off", 32'(if_a.pat_valid), 32'd0);
    check_val("zero_busy_off", 32'(busy_a), 32'd0);

    // 34 patterns wrap the 5-bit counter: ..., 31, 0, 1
    start_run(16'd34);
    for (int i = 0; i < 34; i++) begin
      send_pat(5'(i), ((i % 2) == 1) ? 8'hFF : 8'h00);
    end
    expect_done(4'b0000, 3'd0, 1'b0);

    // LFSR engine: seed 0 becomes 00001, then 00010
    cnt_b   = 16'd5;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_val("lfsr_valid", 32'(if_b.pat_valid), 32'd1);
    check_val("lfsr_first", 32'(if_b.pat_data), 32'h01);
    if_b.pat_ready = 1'b1;
    @(negedge clk);
    if_b.pat_ready = 1'b0;
    check_val("lfsr_rsp_ready", 32'(if_b.rsp_ready), 32'd1);
    if_b.rsp_valid = 1'b1;
    @(negedge clk);
    if_b.rsp_valid = 1'b0;
    @(negedge clk);
    check_val("lfsr_second", 32'(if_b.pat_data), 32'h02);
    if_b.pat_ready = 1'b1;
    @(negedge clk);
    if_b.pat_ready = 1'b0;
    check_val("lfsr_wait", 32'(if_b.rsp_ready), 32'd1);

    // Asynchronous reset during WAIT
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_outputs", {25'd0, if_b.pat_valid, if_b.rsp_ready, busy_b, done_b,
                                alld_b, det_b[0], 1'b0}, 32'd0);
    check_val("abort_pat_data", 32'(if_b.pat_data), 32'd0);
    check_val("abort_det_count", 32'(dc_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort_no_done", 32'(done_b), 32'd0);
      check_val("abort_idle", 32'(busy_b), 32'd0);
    end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_val("restart_first", 32'(if_b.pat_data), 32'h01);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
